// File: rtl/spi_master_param.sv
// spi_master_param: full-duplex SPI master with a configurable word width and chip-select count.
// It supports run-time CPOL/CPHA, a programmable SCLK divider and a start/busy/done handshake.
// Defining SPI_MASTER_LOOPBACK_EN adds a loopback input that feeds SPI_MOSI back into the receive path.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1,
  parameter int DIV_W = 8,
  localparam int CS_W = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              SPI_CLK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [NUM_CS-1:0] SPI_EN
);
  localparam logic [1:0] IDLE = 2'd0, LEAD = 2'd1, XFER = 2'd2, TRAIL = 2'd3;
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_W - 1);
  logic [1:0] state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, h_q;
  logic [EW-1:0] e_q, ei;
  logic [DATA_W-1:0] sh_q, rx_sh_q, rx_q;
  logic [CS_W-1:0] cs_q;
  logic cpha_q, sclk_q, mosi_q, done_q, accept, tick, edge_en, lead_edge, sample, shift, miso_s;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_q;
  assign miso_s = lb_q ? mosi_q : SPI_MISO;
  // loopback select is held for the whole transfer
  always_ff @(posedge clk or posedge rst)
    if (rst) lb_q <= 1'b0;
    else if (accept) lb_q <= loopback;
`else
  assign miso_s = SPI_MISO;
`endif
  // edge bookkeeping: ei is the index of the SCLK edge firing this cycle, even = leading
  always_comb begin
    accept = start && state_q == IDLE;
    tick = state_q != IDLE && cnt_q == '0;
    edge_en = tick && (state_q == LEAD || (state_q == XFER && e_q != LAST));
    ei = state_q == LEAD ? '0 : e_q + 1'b1;
    lead_edge = ~ei[0];
    sample = edge_en && (lead_edge != cpha_q);
    shift = edge_en && (lead_edge == cpha_q) && ei != LAST;
    state_d = accept ? LEAD : !tick ? state_q : state_q == LEAD ? XFER :
              state_q == XFER ? (e_q == LAST ? TRAIL : XFER) : IDLE;
    cnt_d = accept ? clk_div : tick ? h_q : state_q == IDLE ? cnt_q : cnt_q - 1'b1;
  end
  // FSM, half-period down-counter and edge index
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      e_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (edge_en) e_q <= ei;
    end
  // transfer configuration captured at acceptance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_q <= '0;
      cs_q <= '0;
      cpha_q <= 1'b0;
    end else if (accept) begin
      h_q <= clk_div;
      cs_q <= cs_sel;
      cpha_q <= cpha;
    end
  // SCLK follows cpol while idle so LEAD starts at the latched polarity; shift/sample paths
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      sh_q <= '0;
      rx_sh_q <= '0;
      rx_q <= '0;
      done_q <= 1'b0;
    end else begin
      sclk_q <= state_q == IDLE ? cpol : edge_en ? ~sclk_q : sclk_q;
      mosi_q <= accept ? (cpha ? mosi_q : tx_data[DATA_W-1]) : shift ? sh_q[DATA_W-1] : mosi_q;
      sh_q <= accept ? (cpha ? tx_data : tx_data << 1) : shift ? sh_q << 1 : sh_q;
      rx_sh_q <= sample ? {rx_sh_q[DATA_W-2:0], miso_s} : rx_sh_q;
      rx_q <= tick && state_q == TRAIL ? rx_sh_q : rx_q;
      done_q <= tick && state_q == TRAIL;
    end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign rx_data = rx_q;
  assign SPI_CLK = sclk_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_EN = (busy && 32'(cs_q) < NUM_CS) ? NUM_CS'(1) << cs_q : '0;
endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: directed-vector bench for spi_master_param with a small SPI slave model
module tb_spi_master_param;
  logic clk = 0, rst = 1, start = 0, cpol = 0, cpha = 0, SPI_MISO = 0, s_prev = 0;
  logic [7:0] tx_data = 0, clk_div = 0, s_word = 0, s_cap = 0;
  logic [1:0] cs_sel = 0;
  logic busy, done, SPI_CLK, SPI_MOSI;
  logic [7:0] rx_data;
  logic [2:0] SPI_EN, en_or;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic loopback = 0;
`endif
  int n_pass = 0, n_chk = 0, lat, en_first, en_last, s_n, dones, idx;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .busy(busy), .done(done),
    .rx_data(rx_data), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback),
`endif
    .SPI_EN(SPI_EN));

  // slave: detects SCLK edges at negedge, drives MISO for the next sample, captures MOSI
  always @(negedge clk) begin
    if (!busy) begin
      s_n = 0;
      SPI_MISO = s_word[7];
    end else if (SPI_CLK != s_prev) begin
      s_n++;
      if ((s_n % 2 == 1) != cpha) s_cap = {s_cap[6:0], SPI_MOSI};
      idx = 7 - (cpha ? (s_n - 1) / 2 : s_n / 2);
      if (idx >= 0) SPI_MISO = s_word[idx];
    end
    s_prev = SPI_CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic setup(input logic [7:0] tx, input logic [1:0] cs, input logic pol,
                       input logic pha, input logic [7:0] div, input logic [7:0] sw);
    @(negedge clk);
    tx_data = tx; cs_sel = cs; cpol = pol; cpha = pha; clk_div = div; s_word = sw;
    @(negedge clk);
  endtask

  task automatic go;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int k0);
    int k = k0;
    en_or = 0; en_first = 0; en_last = 0;
    while (!done && k < 4000) begin
      if (SPI_EN != 0) begin
        en_or |= SPI_EN;
        if (en_first == 0) en_first = k;
        en_last = k;
      end
      @(negedge clk);
      k++;
    end
    lat = k;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rx", 32'(rx_data), 0);
    check("rst_sclk", 32'(SPI_CLK), 0);
    check("rst_mosi", 32'(SPI_MOSI), 0);
    check("rst_en", 32'(SPI_EN), 0);
    rst = 0;

    setup(8'hA5, 0, 0, 0, 1, 8'h3C);
    go;
    wait_done(1);
    check("m0_lat", lat, 37);
    check("m0_rx", 32'(rx_data), 32'h3C);
    check("m0_mosi", 32'(s_cap), 32'hA5);
    check("m0_en_first", en_first, 1);
    check("m0_en_last", en_last, 36);
    check("m0_en_sel", 32'(en_or), 1);

    setup(8'h81, 2, 1, 1, 0, 8'hF0);
    check("m3_idle_sclk", 32'(SPI_CLK), 1);
    go;
    wait_done(1);
    check("m3_lat", lat, 19);
    check("m3_rx", 32'(rx_data), 32'hF0);
    check("m3_mosi", 32'(s_cap), 32'h81);
    check("m3_en_sel", 32'(en_or), 32'b100);
    check("m3_en_last", en_last, 18);

    setup(8'hA5, 0, 0, 0, 1, 8'h3C);
    go;
    repeat (8) @(negedge clk);
    tx_data = 8'h11; start = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    tx_data = 8'h22; start = 1;
    wait_done(20);
    check("b2b_lat", lat, 37);
    check("b2b_first_word", 32'(s_cap), 32'hA5);
    check("b2b_done_busy", 32'(busy), 0);
    check("b2b_done_en", 32'(SPI_EN), 0);
    @(negedge clk);
    start = 0;
    check("b2b_next_busy", 32'(busy), 1);
    check("b2b_next_en", 32'(SPI_EN), 1);
    wait_done(1);
    check("b2b_lat2", lat, 37);
    check("b2b_second_word", 32'(s_cap), 32'h22);

    setup(8'hA5, 0, 0, 0, 1, 8'h3C);
    go;
    repeat (10) @(posedge clk);
    #1;
    check("rmid_sclk_before", 32'(SPI_CLK), 1);
    check("rmid_en_before", 32'(SPI_EN), 1);
    rst = 1;
    #1;
    check("rmid_en", 32'(SPI_EN), 0);
    check("rmid_busy", 32'(busy), 0);
    check("rmid_sclk", 32'(SPI_CLK), 0);
    check("rmid_rx", 32'(rx_data), 0);
    check("rmid_done", 32'(done), 0);
    @(negedge clk);
    rst = 0;
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rmid_no_done", dones, 0);

    setup(8'hA5, 3, 0, 0, 1, 8'h96);
    go;
    wait_done(1);
    check("oor_en", 32'(en_or), 0);
    check("oor_lat", lat, 37);
    check("oor_rx", 32'(rx_data), 32'h96);

`ifdef SPI_MASTER_LOOPBACK_EN
    loopback = 1;
    setup(8'h5A, 0, 0, 0, 0, 8'h00);
    go;
    loopback = 0;
    wait_done(1);
    check("lb_lat", lat, 19);
    check("lb_rx", 32'(rx_data), 32'h5A);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
